booth_mul_sched: RTL

Sequencing and arbitration controller for a shared iterative radix-2 Booth signed multiplier. NREQ requesters submit operand pairs through valid/ready handshakes. A round-robin arbiter grants one request at a time and runs one Booth add/subtract/shift step per clock. The signed product is returned on a single response channel tagged with the requester ID. It sits between client blocks that need occasional signed multiplies and one multiplier datapath, replacing per-client combinational multipliers.

---
 rtl/booth_sched_pkg.sv | 8 +
 rtl/booth_step.sv | 23 ++
 rtl/booth_mul_sched.sv | 108 ++++++++++
 3 files changed

// File: rtl/booth_sched_pkg.sv
// booth_sched_pkg: shared FSM states, Booth op codes and stats width for booth_mul_sched
package booth_sched_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [1:0] NOP = 2'b00;
   localparam logic [1:0] ADD = 2'b01;
   localparam logic [1:0] SUB = 2'b10;
   localparam int STATS_W = 16;
endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration (add/sub then arithmetic shift right)
module booth_step
   import booth_sched_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic             q_1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   acc_n,
   output logic [WIDTH-1:0] q_n,
   output logic             q_1_n
);
   logic [1:0]     op;
   logic [WIDTH:0] sum;
   // 00 and 11 both collapse to NOP so only the add/sub cases need decoding
   always_comb begin
      op  = (q[0] ^ q_1) ? {q[0], q_1} : NOP;
      sum = (op == ADD) ? acc + m : (op == SUB) ? acc - m : acc;
   end
   assign {acc_n, q_n, q_1_n} = {sum[WIDTH], sum, q};
endmodule

// File: rtl/booth_mul_sched.sv
// booth_mul_sched: round-robin scheduler for a shared iterative Booth multiplier; BOOTH_SCHED_STATS_EN adds ops_done/busy
module booth_mul_sched
   import booth_sched_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int NREQ  = 2,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_p
`ifdef BOOTH_SCHED_STATS_EN
   ,
   output logic [STATS_W-1:0]    ops_done,
   output logic                  busy
`endif
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [IDW:0] NR = (IDW+1)'(NREQ);
   state_t           state;
   logic [IDW-1:0]   ptr, g, off, id;
   logic [IDW:0]     sum;
   logic [2*NREQ-1:0] rot;
   logic             hit;
   logic [WIDTH:0]   acc, m, acc_n;
   logic [WIDTH-1:0] q, q_n, a_sel, b_sel;
   logic             q_1, q_1_n;
   logic [CW-1:0]    cnt;
   // rotate requests so ptr sits at bit 0, take the lowest set offset, map back to an absolute index
   always_comb begin
      rot = {req_valid, req_valid} >> ptr;
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (rot[i]) off = IDW'(i);
      sum = {1'b0, ptr} + {1'b0, off};
      g   = (sum >= NR) ? IDW'(sum - NR) : sum[IDW-1:0];
   end
   assign hit       = |req_valid;
   assign req_ready = (state == IDLE && hit) ? NREQ'(1) << g : '0;
   assign a_sel     = req_a[g*WIDTH +: WIDTH];
   assign b_sel     = req_b[g*WIDTH +: WIDTH];
   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc(acc), .q(q), .q_1(q_1), .m(m),
      .acc_n(acc_n), .q_n(q_n), .q_1_n(q_1_n)
   );
   // accept in IDLE, iterate WIDTH Booth steps in RUN, hold the product in DONE until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         id        <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_p     <= '0;
         acc       <= '0;
         m         <= '0;
         q         <= '0;
         q_1       <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: if (hit) begin
               m     <= {a_sel[WIDTH-1], a_sel};
               acc   <= '0;
               q     <= b_sel;
               q_1   <= 1'b0;
               cnt   <= CW'(WIDTH - 1);
               id    <= g;
               ptr   <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
               state <= RUN;
            end
            RUN: begin
               acc <= acc_n;
               q   <= q_n;
               q_1 <= q_1_n;
               if (cnt == '0) begin
                  state     <= DONE;
                  rsp_valid <= 1'b1;
                  rsp_id    <= id;
                  rsp_p     <= {acc_n[WIDTH-1:0], q_n};
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef BOOTH_SCHED_STATS_EN
   // count accepted responses; 16-bit wrap is intentional
   always_ff @(posedge clk) begin
      if (rst) ops_done <= '0;
      else if (rsp_valid && rsp_ready) ops_done <= ops_done + 1'b1;
   end
   assign busy = state != IDLE;
`endif
endmodule
